// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//
// 8N1 UART transmitter. Takes one byte per valid/ready handshake and sends it
// LSB first on o_tx as one start bit (low), eight data bits and STOP_BITS
// stop bits (high). The line idles high. Every bit lasts exactly
// TICKS_PER_BIT clock cycles.
//
// After a frame there is always one idle cycle with o_ready high before the
// next byte can be taken. Back-to-back frames therefore repeat every
// (9 + STOP_BITS) * TICKS_PER_BIT + 1 cycles.
//
// Parameters
//   BAUD_RATE   line bit rate in bits/s
//   CLOCK_FREQ  i_clk frequency in Hz
//   STOP_BITS   number of stop bits, 1 or 2
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       synchronous, active-high reset
//   i_data_in     byte to send, sampled only on the accepting edge
//   i_data_valid  producer has a byte on i_data_in
//   o_ready       transmitter takes a byte on this edge if i_data_valid is high
//   o_tx          serial line, idle high
//   o_busy        frame in progress, always ~o_ready
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000,
    parameter int STOP_BITS  = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data_in,
    input  logic       i_data_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    // The guard keeps the width legal so the $error below is what the user
    // sees when TICKS_PER_BIT is too small.
    localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (TICKS_PER_BIT < 2) begin : g_bad_ticks
            $error("uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_ready;
    logic              r_busy;

    logic              w_accept;
    logic              w_tick_last;

    // o_ready is a register, so the accept term never feeds back into it
    // combinationally.
    assign w_accept    = i_data_valid && r_ready;
    assign w_tick_last = (r_tick == TICK_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        // The start bit goes out on the very next cycle.
                        r_shift   <= i_data_in;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_tick    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                    end
                end

                S_START: begin
                    if (w_tick_last) begin
                        r_tick    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_tick_last) begin
                        r_tick  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_tx      <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            // Next bit comes from the shifted value.
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick_last) begin
                        r_tick <= '0;
                        // The bit index is reused to count stop bits.
                        if (r_bit_idx == STOP_LAST) begin
                            r_bit_idx <= '0;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_tick    <= '0;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b1;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_tx    = r_tx;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
//
// Drives two uart_tx instances at 10 clocks per bit: one with one stop bit
// (scoreboarded through a line monitor), one with two stop bits (checked
// cycle by cycle).
// ----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int T = 10;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       valid2;
    logic       ready2;
    logic       tx2;
    logic       busy2;

    int         cyc;
    int         n_checks;
    int         n_fail;

    logic [7:0] exp_q[$];
    int         frames_done;
    int         frames_aborted;
    bit         m_active;
    int         m_k;
    int         m_n;
    logic [7:0] m_byte;
    logic [7:0] m_exp;

    uart_tx #(.BAUD_RATE(100), .CLOCK_FREQ(1000), .STOP_BITS(1)) dut (
        .i_clk(clk), .i_reset(rst), .i_data_in(data_in), .i_data_valid(valid),
        .o_ready(ready), .o_tx(tx), .o_busy(busy)
    );

    uart_tx #(.BAUD_RATE(100), .CLOCK_FREQ(1000), .STOP_BITS(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_data_in(data_in), .i_data_valid(valid2),
        .o_ready(ready2), .o_tx(tx2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Line monitor for dut: decodes frames at mid-bit and checks them against
    // the scoreboard. A reset during a frame drops the expected byte.
    initial begin
        m_active = 0; m_k = 0; m_n = 0; m_byte = '0;
        frames_done = 0; frames_aborted = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (m_active) begin
                    m_active = 0;
                    frames_aborted++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end else begin
                if (!m_active) begin
                    if (tx === 1'b0) begin
                        m_active = 1;
                        m_k = 0;
                    end
                end else begin
                    m_k++;
                end
                if (m_active && (m_k % T == T / 2)) begin
                    m_n = m_k / T;
                    if (m_n == 0) begin
                        n_checks++;
                        if (tx !== 1'b0) begin
                            n_fail++;
                            $display("FAIL mon_start_bit: got %b, required 0", tx);
                        end
                    end else if (m_n <= 8) begin
                        m_byte[m_n-1] = tx;
                    end else begin
                        n_checks++;
                        if (tx !== 1'b1) begin
                            n_fail++;
                            $display("FAIL mon_stop_bit: got %b, required 1", tx);
                        end
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL mon_unexpected_frame: got byte %02h, required no frame", m_byte);
                        end else begin
                            m_exp = exp_q.pop_front();
                            if (m_byte !== m_exp) begin
                                n_fail++;
                                $display("FAIL mon_frame_byte: got %02h, required %02h", m_byte, m_exp);
                            end
                        end
                        frames_done++;
                        m_active = 0;
                    end
                end
            end
        end
    end

    function automatic logic exp_line(input logic [7:0] b, input int k);
        int n;
        n = k / T;
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        return 1'b1;
    endfunction

    // Called at a negedge. Returns at the negedge just after the accepting
    // edge; a_cyc is the cycle number seen there.
    task automatic send_byte(input logic [7:0] b, input bit hold, output int a_cyc);
        bit ok;
        ok = 0;
        a_cyc = 0;
        data_in = b;
        valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (ready === 1'b1) begin
                @(posedge clk);
                exp_q.push_back(b);
                ok = 1;
                @(negedge clk);
                a_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!hold) valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_accept: byte %02h got no accept, required accept within 500 cycles", b);
        end
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 300 && frames_done < target; i++) @(negedge clk);
        n_checks++;
        if (frames_done < target) begin
            n_fail++;
            $display("FAIL wait_frames: got %0d frames, required %0d", frames_done, target);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b0; valid2 = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        // Request during reset must be ignored.
        valid = 1'b1; valid2 = 1'b1; data_in = 8'h99;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (ready2 !== 1'b1 || tx2 !== 1'b1 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut2: got ready=%b tx=%b busy=%b, required 1 1 0", ready2, tx2, busy2);
        end
        valid = 1'b0; valid2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || frames_done != 0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got tx=%b ready=%b frames=%0d, required 1 1 0", tx, ready, frames_done);
        end
    endtask

    task automatic test_single;
        int a;
        int bad_tx, bad_rdy;
        bad_tx = 0; bad_rdy = 0;
        send_byte(8'hA5, 0, a);
        for (int k = 0; k <= 100; k++) begin
            if (tx !== exp_line(8'hA5, k)) bad_tx++;
            if (ready !== (k >= 100) || busy !== (k < 100)) bad_rdy++;
            if (k < 100) @(negedge clk);
        end
        n_checks++;
        if (bad_tx != 0) begin n_fail++; $display("FAIL single_tx_pattern: got %0d wrong cycles, required 0", bad_tx); end
        n_checks++;
        if (bad_rdy != 0) begin n_fail++; $display("FAIL single_ready_window: got %0d wrong cycles, required 0", bad_rdy); end
        wait_frames(1);
    endtask

    task automatic test_back_to_back;
        int a1, a2;
        send_byte(8'h00, 1, a1);
        send_byte(8'hFF, 0, a2);
        n_checks++;
        if (a2 - a1 != 101) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, required 101", a2 - a1);
        end
        wait_frames(3);
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || frames_done != 3) begin
            n_fail++;
            $display("FAIL b2b_frame_count: got %0d frames, %0d pending, required 3, 0", frames_done, exp_q.size());
        end
    endtask

    task automatic test_ignored;
        int a;
        int lows;
        lows = 0;
        send_byte(8'h81, 0, a);
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 35) begin data_in = 8'h3C; valid = 1'b1; end
            if (k == 36) valid = 1'b0;
            if (k == 50) data_in = 8'hFF;
            if (k > 100 && tx !== 1'b1) lows++;
        end
        n_checks++;
        if (frames_done != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ignored_frames: got %0d frames, %0d pending, required 4, 0", frames_done, exp_q.size());
        end
        n_checks++;
        if (lows != 0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_no_second_frame: got %0d low cycles ready=%b, required 0 low, ready 1", lows, ready);
        end
    endtask

    task automatic test_reset_mid;
        int a;
        send_byte(8'h55, 0, a);
        repeat (55) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got tx=%b ready=%b busy=%b, required 1 1 0", tx, ready, busy);
        end
        #2 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frames_aborted != 1 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got aborted=%0d tx=%b, required 1, 1", frames_aborted, tx);
        end
        send_byte(8'h12, 0, a);
        wait_frames(5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_pending: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stop2;
        int bad_tx, bad_rdy;
        bit ok;
        bad_tx = 0; bad_rdy = 0; ok = 0;
        data_in = 8'hC3;
        valid2 = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (ready2 === 1'b1) ok = 1;
            else @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        data_in = 8'h00;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stop2_accept: got no ready, required ready"); end
        for (int k = 0; k <= 110; k++) begin
            if (tx2 !== exp_line(8'hC3, k)) bad_tx++;
            if (ready2 !== (k >= 110) || busy2 !== (k < 110)) bad_rdy++;
            if (k < 110) @(negedge clk);
        end
        n_checks++;
        if (bad_tx != 0) begin n_fail++; $display("FAIL stop2_tx_pattern: got %0d wrong cycles, required 0", bad_tx); end
        n_checks++;
        if (bad_rdy != 0) begin n_fail++; $display("FAIL stop2_ready_at_110: got %0d wrong cycles, required 0", bad_rdy); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        valid = 1'b0;
        valid2 = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_stop2();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter, the transmit-side counterpart of the team's UART receiver. It accepts one byte per valid/ready handshake and serialises it LSB-first on `tx` as one start bit, 8 data bits and STOP_BITS stop bits. It sits between the hasher result path and the board TX pin, sharing the same clock and baud parameters as the receive path.

Parameters:
- BAUD_RATE, 9600, line bit rate in bits/s.
- CLOCK_FREQ, 50000000, `clk` frequency in Hz.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- TICKS_PER_BIT (localparam), CLOCK_FREQ/BAUD_RATE with integer truncation, `clk` cycles per bit. Must be >= 2; elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  byte to transmit; sampled only on accept.
- data_valid  in  1  producer has a byte on `data_in`.
- ready  out  1  transmitter can accept a byte this cycle (registered).
- tx  out  1  serial line; idle high.
- busy  out  1  frame in progress (registered); equals ~ready.

Behaviour:
- Reset: sampled on clk edge when reset=1.
  - tx=1, ready=1, busy=0.
  - State IDLE; bit counter, tick counter and shift register cleared.
  - Reset mid-frame aborts the frame: tx is high from the next edge, with no partial stop bit.
- Accept: the edge where data_valid && ready = edge A. On edge A:
  - shift register <= data_in;
  - tx <= 0 (start bit);
  - ready <= 0, busy <= 1;
  - tick counter <= 0, state <= START.
  - Latency from accept to line activity is zero extra cycles: tx is low in the cycle after edge A.
- Tick counter: counts 0..TICKS_PER_BIT-1 within each bit. At count TICKS_PER_BIT-1 it wraps to 0 and the FSM advances. Every bit is therefore exactly TICKS_PER_BIT cycles. Counter width is $clog2(TICKS_PER_BIT).
- State machine:
  - IDLE: tx=1; waits for accept, then goes to START.
  - START: tx=0 for one bit time, then DATA with bit index 0.
  - DATA: tx = shift register[0] for one bit time. At the end of each bit, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for STOP_BITS bit times, then IDLE.
- Timing:
  - Bit n (start=0, data 1..8, stop 9..) begins at edge A + n*TICKS_PER_BIT.
  - At edge A + (9+STOP_BITS)*TICKS_PER_BIT: state <= IDLE, ready <= 1, busy <= 0.
  - Earliest next accept is the following edge, so back-to-back frames have a minimum period of (9+STOP_BITS)*TICKS_PER_BIT + 1 cycles.
  - The extra idle cycle is deliberate and guaranteed.
- Handshake rules:
  - data_valid while ready=0 is ignored; no byte is queued.
  - data_in may change freely after edge A without affecting the frame in flight.
  - data_valid need not be held; the producer holds it until it sees ready=1 on a sampling edge.
  - ready does not depend combinationally on data_valid.
- Simultaneous events: reset=1 and data_valid=1 on the same edge → reset wins, nothing is accepted, ready=1 afterwards.
- tx is a registered output with no glitches. The idle line level is 1 at all times outside START/DATA.

Test Plan:
- Use CLOCK_FREQ=1000, BAUD_RATE=100 (TICKS_PER_BIT=10) unless stated.
- Single byte: send 0xA5 after reset → tx sequence, each bit 10 cycles: 0 | 1,0,1,0,0,1,0,1 | 1. ready is 0 for exactly 100 cycles after edge A, then 1.
- Back-to-back: hold data_valid=1 with 0x00 then 0xFF → second start bit falls exactly 101 cycles after the first. Frame 1 has all data bits 0; frame 2 has all data bits 1. No bytes are lost or duplicated.
- Ignored request: pulse data_valid with 0x3C at cycle 35 of a 0x81 frame, and change data_in mid-frame → the line carries only 0x81, with the correct LSB-first pattern. No second frame follows.
- Reset mid-frame: assert reset for 1 cycle during data bit 4 of 0x55 → tx=1, ready=1, busy=0 on the next cycle. A subsequent 0x12 frame is correct.
- STOP_BITS=2, byte 0xC3 → stop level high for 20 cycles. ready rises at edge A+110.
- Loopback: connect tx to the team's UART receiver at the default 50 MHz/9600 and send 0x00, 0x55, 0xAA, 0xFF, 0x7E → the receiver reports the same 5 bytes in order.
